mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory port between instruction fetch (IFU) and load/store (LSU) for the multi-cycle core.
- Arbitrates round-robin and keeps exactly one transaction outstanding.
- Registers the granted request, drives the memory valid/ready handshake and routes the response back to its owner.
- Adds a response timeout and a sticky protocol-error flag for bring-up debug.

Parameters:
- XLEN, 64, address/data width.
- TIMEOUT, 255, maximum cycles in WAIT before a forced error response (1..2^16-1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted
- ifu_addr  in  XLEN  fetch address
- ifu_resp_valid  out  1  fetch response, one-cycle pulse
- ifu_rdata  out  XLEN  fetch data
- ifu_resp_err  out  1  fetch response is a timeout error
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  load/store request accepted
- lsu_addr  in  XLEN  data address
- lsu_wen  in  1  1 = store
- lsu_wdata  in  XLEN  store data
- lsu_op  in  3  MemOp size/sign code, passed through unchanged
- lsu_resp_valid  out  1  load/store response or store ack, one-cycle pulse
- lsu_rdata  out  XLEN  load data
- lsu_resp_err  out  1  load/store response is a timeout error
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  XLEN  registered address
- mem_wen  out  1  registered write enable
- mem_wdata  out  XLEN  registered write data
- mem_op  out  3  registered MemOp
- mem_resp_valid  in  1  memory response
- mem_rdata  in  XLEN  memory read data
- busy  out  1  state != IDLE
- protocol_err  out  1  sticky: unexpected mem_resp_valid seen

Behaviour:
- States: IDLE, REQ, WAIT.
- Registers: owner (0 = IFU, 1 = LSU), last_grant, addr/wen/wdata/op, timeout counter tcnt, protocol_err.
- Reset, synchronous on rst:
  - state = IDLE, last_grant = IFU, owner = IFU, tcnt = 0, protocol_err = 0.
  - Registered mem_* fields = 0.
  - All outputs low or zero.
  - Any in-flight transaction is dropped and no response is generated for it.
- IDLE, arbitration (combinational):
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant. First tie after reset goes to LSU.
  - Granted requester's req_ready = 1 in the same cycle; the other's req_ready = 0.
  - ready is 0 outside IDLE.
  - On handshake: capture request fields, set owner and last_grant to the winner, go to REQ.
  - IFU grants capture wen = 0, wdata = 0, op = 3'b000.
- REQ:
  - mem_req_valid = 1 with the registered fields, held stable until mem_req_ready.
  - On mem_req_valid && mem_req_ready: tcnt = 0, go to WAIT.
- WAIT:
  - On mem_resp_valid: owner's resp_valid = 1 for that cycle, owner's rdata = mem_rdata (combinational pass-through), resp_err = 0, go to IDLE.
  - Otherwise tcnt increments.
  - When tcnt == TIMEOUT-1 with no response: owner's resp_valid = 1, resp_err = 1, rdata = 0, go to IDLE.
- Response routing:
  - The non-owner's resp_valid is always 0.
  - rdata outputs are 0 whenever their resp_valid = 0.
- Latency:
  - Handshake at cycle N gives mem_req_valid at N+1.
  - mem_req_ready at N+1 gives the earliest response at N+2.
  - The next request can be accepted in the cycle after the response.
  - Back-to-back throughput is one transaction per 3 cycles minimum.
- Protocol:
  - mem_resp_valid in IDLE or REQ is ignored (not forwarded) and sets protocol_err.
  - protocol_err clears only on rst.
  - A late response after a timeout arrives in IDLE, is ignored and sets protocol_err.
- Requesters must hold valid and fields stable until ready. Deasserting before ready is permitted; nothing is captured in that case.
- Stores complete only on mem_resp_valid, which acts as the write ack.

Test Plan:
- Single IFU read: ifu_addr = 0x80000000 for one cycle, mem_req_ready = 1, mem_resp_valid next cycle with rdata = 0x00000013 -> ifu_req_ready at cycle 0, mem_req_valid at cycle 1 with addr 0x80000000, ifu_resp_valid = 1 with rdata 0x13 at cycle 2, busy low at cycle 3.
- Simultaneous requests after reset, IFU 0x80000004 and LSU load 0x80001000 held high -> LSU granted first, then IFU. With both held, grants alternate LSU, IFU, LSU.
- LSU store: wen = 1, wdata = 0xDEADBEEF, op = 3'b011, mem_req_ready delayed 3 cycles -> mem_req_valid held 3 cycles with stable fields, lsu_resp_valid on ack, ifu_resp_valid stays 0.
- Timeout with TIMEOUT = 4: no mem_resp_valid -> owner resp_valid with resp_err = 1 and rdata = 0 after 4 WAIT cycles. A later mem_resp_valid sets protocol_err = 1 and forwards nothing.
- Reset in WAIT: assert rst mid-transaction -> next cycle busy = 0, mem_req_valid = 0, protocol_err = 0, no resp_valid. The next tie is granted to LSU.
- Spurious response: mem_resp_valid in IDLE -> protocol_err = 1 and stays high until rst. Both resp_valid outputs stay 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, memory and status signals around the memory arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding core and memory that drive it.
interface mem_arbiter_if #(
  parameter int XLEN = 64
);
  logic            ifu_req_valid;
  logic            ifu_req_ready;
  logic [XLEN-1:0] ifu_addr;
  logic            ifu_resp_valid;
  logic [XLEN-1:0] ifu_rdata;
  logic            ifu_resp_err;

  logic            lsu_req_valid;
  logic            lsu_req_ready;
  logic [XLEN-1:0] lsu_addr;
  logic            lsu_wen;
  logic [XLEN-1:0] lsu_wdata;
  logic [2:0]      lsu_op;
  logic            lsu_resp_valid;
  logic [XLEN-1:0] lsu_rdata;
  logic            lsu_resp_err;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_wen;
  logic [XLEN-1:0] mem_wdata;
  logic [2:0]      mem_op;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_rdata;

  logic            busy;
  logic            protocol_err;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_op,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_op,
    output busy, protocol_err
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_op,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_op,
    input  busy, protocol_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (IFU) and
// load/store (LSU). It allows a single outstanding transaction, has a response
// timeout, and keeps a sticky flag for responses that arrive when none is expected.
module mem_arbiter #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  REQ       = 2'd1;
  localparam logic [1:0]  WAIT      = 2'd2;
  localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic            owner_q, owner_d;
  logic            lastGrant_q, lastGrant_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      op_q, op_d;
  logic [15:0]     tcnt_q, tcnt_d;
  logic            perr_q, perr_d;

  logic grantIfu, grantLsu, respFire, timeoutFire;

  // Round-robin pick. On a tie the requester that was not granted last time wins (owner/lastGrant: 0 = IFU, 1 = LSU).
  always_comb begin
    grantLsu    = bus.lsu_req_valid && (!bus.ifu_req_valid || !lastGrant_q);
    grantIfu    = bus.ifu_req_valid && (!bus.lsu_req_valid || lastGrant_q);
    respFire    = !rst && (state_q == WAIT) && bus.mem_resp_valid;
    timeoutFire = !rst && (state_q == WAIT) && !bus.mem_resp_valid && (tcnt_q == TCNT_LAST);
  end

  // Handshakes and response routing. Outputs are forced quiet while rst is high, so a dropped transaction never answers.
  always_comb begin
    bus.ifu_req_ready  = !rst && (state_q == IDLE) && grantIfu;
    bus.lsu_req_ready  = !rst && (state_q == IDLE) && grantLsu;
    bus.ifu_resp_valid = (respFire || timeoutFire) && !owner_q;
    bus.lsu_resp_valid = (respFire || timeoutFire) && owner_q;
    bus.ifu_resp_err   = timeoutFire && !owner_q;
    bus.lsu_resp_err   = timeoutFire && owner_q;
    bus.ifu_rdata      = (respFire && !owner_q) ? bus.mem_rdata : '0;
    bus.lsu_rdata      = (respFire && owner_q) ? bus.mem_rdata : '0;
    bus.mem_req_valid  = !rst && (state_q == REQ);
    bus.mem_addr       = addr_q;
    bus.mem_wen        = wen_q;
    bus.mem_wdata      = wdata_q;
    bus.mem_op         = op_q;
    bus.busy           = (state_q != IDLE);
    bus.protocol_err   = perr_q;
  end

  // Next-state logic: capture the winner in IDLE, hold the request in REQ, wait for the response or the timeout in WAIT.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    op_d        = op_q;
    tcnt_d      = tcnt_q;
    perr_d      = perr_q | (bus.mem_resp_valid && (state_q != WAIT));
    case (state_q)
      IDLE: begin
        if (grantLsu) begin
          owner_d     = 1'b1;
          lastGrant_d = 1'b1;
          addr_d      = bus.lsu_addr;
          wen_d       = bus.lsu_wen;
          wdata_d     = bus.lsu_wdata;
          op_d        = bus.lsu_op;
          state_d     = REQ;
        end else if (grantIfu) begin
          owner_d     = 1'b0;
          lastGrant_d = 1'b0;
          addr_d      = bus.ifu_addr;
          wen_d       = 1'b0;
          wdata_d     = '0;
          op_d        = 3'b000;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          tcnt_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_resp_valid || (tcnt_q == TCNT_LAST)) begin
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      lastGrant_q <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      op_q        <= 3'b000;
      tcnt_q      <= '0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      op_q        <= op_d;
      tcnt_q      <= tcnt_d;
      perr_q      <= perr_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. It plays both requesters and the memory, and
// predicts the grant order and the responses from the arbitration rules.
// Expected responses go into a queue that a negedge monitor drains.
module tb_mem_arbiter;

  localparam int XLEN    = 64;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(XLEN)) bus ();

  mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic            owner;
    logic            err;
    logic [XLEN-1:0] data;
  } resp_t;

  resp_t expQ[$];
  int    vectors     = 0;
  int    miscompares = 0;

  logic            pendIfu, pendLsu;
  logic [XLEN-1:0] ifuAddr, lsuAddr, lsuWdata;
  logic            lsuWen;
  logic [2:0]      lsuOp;
  logic            modelLast;
  logic            expPerr;

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    bus.mem_rdata = {$urandom, $urandom};
  endtask

  task automatic applyStimulus();
    bus.ifu_req_valid = pendIfu;
    bus.ifu_addr      = ifuAddr;
    bus.lsu_req_valid = pendLsu;
    bus.lsu_addr      = lsuAddr;
    bus.lsu_wen       = lsuWen;
    bus.lsu_wdata     = lsuWdata;
    bus.lsu_op        = lsuOp;
  endtask

  // mode 0: normal response, mode 1: timeout (optionally followed by a late response), mode 2: reset while in WAIT
  task automatic runTxn(input int reqDelay, input int respDelay, input int mode,
                        input logic [XLEN-1:0] data, input bit late);
    logic            winner;
    logic [XLEN-1:0] eAddr, eWdata;
    logic            eWen;
    logic [2:0]      eOp;
    resp_t           r;
    applyStimulus();
    winner = (pendIfu && pendLsu) ? ~modelLast : pendLsu;
    @(negedge clk);
    checkBit("busy_idle", bus.busy, 1'b0);
    checkBit("perr_sticky", bus.protocol_err, expPerr);
    checkBit("ifu_req_ready", bus.ifu_req_ready, !winner);
    checkBit("lsu_req_ready", bus.lsu_req_ready, winner);
    if (winner) begin
      eAddr = lsuAddr; eWen = lsuWen; eWdata = lsuWdata; eOp = lsuOp;
      pendLsu = 1'b0;
    end else begin
      eAddr = ifuAddr; eWen = 1'b0; eWdata = '0; eOp = 3'b000;
      pendIfu = 1'b0;
    end
    modelLast = winner;
    nextCycle();
    applyStimulus();
    for (int k = 0; k <= reqDelay; k++) begin
      bus.mem_req_ready = (k == reqDelay);
      @(negedge clk);
      checkBit("mem_req_valid", bus.mem_req_valid, 1'b1);
      checkOutput("mem_addr", bus.mem_addr, eAddr);
      checkBit("mem_wen", bus.mem_wen, eWen);
      checkOutput("mem_wdata", bus.mem_wdata, eWdata);
      checkOutput("mem_op", 64'(bus.mem_op), 64'(eOp));
      checkBit("ready_low_req", bus.ifu_req_ready | bus.lsu_req_ready, 1'b0);
      nextCycle();
    end
    bus.mem_req_ready = 1'b0;
    if (mode == 2) begin
      rst = 1'b1;
      bus.mem_resp_valid = 1'b1;
      @(negedge clk);
      nextCycle();
      rst = 1'b0;
      bus.mem_resp_valid = 1'b0;
      pendIfu = 1'b0;
      pendLsu = 1'b0;
      applyStimulus();
      modelLast = 1'b0;
      expPerr = 1'b0;
      @(negedge clk);
      checkBit("rst_busy", bus.busy, 1'b0);
      checkBit("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
      checkBit("rst_perr", bus.protocol_err, 1'b0);
      checkOutput("rst_mem_addr", bus.mem_addr, '0);
      nextCycle();
    end else if (mode == 1) begin
      for (int k = 0; k < TIMEOUT; k++) begin
        if (k == TIMEOUT - 1) begin
          r.owner = winner; r.err = 1'b1; r.data = '0;
          expQ.push_back(r);
        end
        @(negedge clk);
        checkBit("wait_no_req", bus.mem_req_valid, 1'b0);
        checkBit("ready_low_wait", bus.ifu_req_ready | bus.lsu_req_ready, 1'b0);
        if (k == TIMEOUT - 1) begin
          #1;
          checkBit("timeout_resp_seen", expQ.size() == 0, 1'b1);
          expQ.delete();
        end
        nextCycle();
      end
      if (late) begin
        bus.ifu_req_valid  = 1'b0;
        bus.lsu_req_valid  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        @(negedge clk);
        nextCycle();
        bus.mem_resp_valid = 1'b0;
        expPerr = 1'b1;
        @(negedge clk);
        checkBit("late_perr", bus.protocol_err, 1'b1);
        checkBit("late_busy", bus.busy, 1'b0);
        nextCycle();
      end
    end else begin
      for (int k = 0; k <= respDelay; k++) begin
        if (k == respDelay) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_rdata = data;
          r.owner = winner; r.err = 1'b0; r.data = data;
          expQ.push_back(r);
        end
        @(negedge clk);
        checkBit("wait_no_req", bus.mem_req_valid, 1'b0);
        checkBit("ready_low_wait", bus.ifu_req_ready | bus.lsu_req_ready, 1'b0);
        if (k == respDelay) begin
          #1;
          checkBit("resp_seen", expQ.size() == 0, 1'b1);
          expQ.delete();
        end
        nextCycle();
      end
      bus.mem_resp_valid = 1'b0;
    end
  endtask

  // Response monitor: every presented response must match the next expected one, and idle rdata must be zero.
  always @(negedge clk) begin
    resp_t e;
    if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_resp: ifu_resp_valid=%b lsu_resp_valid=%b, expected none at %0t",
                 bus.ifu_resp_valid, bus.lsu_resp_valid, $time);
      end else begin
        e = expQ.pop_front();
        checkBit("resp_ifu_valid", bus.ifu_resp_valid, !e.owner);
        checkBit("resp_lsu_valid", bus.lsu_resp_valid, e.owner);
        checkBit("resp_err", e.owner ? bus.lsu_resp_err : bus.ifu_resp_err, e.err);
        checkOutput("resp_rdata", e.owner ? bus.lsu_rdata : bus.ifu_rdata, e.data);
      end
    end
    if (!bus.ifu_resp_valid) checkOutput("ifu_rdata_idle", bus.ifu_rdata, '0);
    if (!bus.lsu_resp_valid) checkOutput("lsu_rdata_idle", bus.lsu_rdata, '0);
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized stream.
  initial begin
    rst = 1'b1;
    pendIfu = 1'b0; pendLsu = 1'b0;
    ifuAddr = '0; lsuAddr = '0; lsuWdata = '0; lsuWen = 1'b0; lsuOp = 3'b000;
    modelLast = 1'b0; expPerr = 1'b0;
    applyStimulus();
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkBit("reset_busy", bus.busy, 1'b0);
    checkBit("reset_mem_req_valid", bus.mem_req_valid, 1'b0);
    checkOutput("reset_mem_addr", bus.mem_addr, '0);
    checkBit("reset_perr", bus.protocol_err, 1'b0);
    checkBit("reset_ready", bus.ifu_req_ready | bus.lsu_req_ready, 1'b0);
    nextCycle();

    $display("[TB] single IFU read");
    pendIfu = 1'b1; ifuAddr = 64'h8000_0000;
    runTxn(0, 0, 0, 64'h13, 1'b0);

    $display("[TB] simultaneous requests alternate LSU, IFU, LSU");
    pendIfu = 1'b1; ifuAddr = 64'h8000_0004;
    pendLsu = 1'b1; lsuAddr = 64'h8000_1000; lsuWen = 1'b0; lsuWdata = '0; lsuOp = 3'b010;
    runTxn(0, 0, 0, 64'h1111, 1'b0);
    pendLsu = 1'b1;
    runTxn(0, 1, 0, 64'h2222, 1'b0);
    pendIfu = 1'b1;
    runTxn(0, 0, 0, 64'h3333, 1'b0);
    pendIfu = 1'b0;
    applyStimulus();

    $display("[TB] LSU store with delayed mem_req_ready");
    pendLsu = 1'b1; lsuAddr = 64'h8000_2000; lsuWen = 1'b1; lsuWdata = 64'hDEAD_BEEF; lsuOp = 3'b011;
    runTxn(3, 2, 0, 64'h0, 1'b0);

    $display("[TB] timeout then late response");
    pendIfu = 1'b1; ifuAddr = 64'h8000_0040;
    runTxn(0, 0, 1, 64'h0, 1'b1);

    $display("[TB] reset in WAIT");
    pendLsu = 1'b1; lsuAddr = 64'h8000_3000; lsuWen = 1'b0; lsuOp = 3'b001;
    runTxn(1, 0, 2, 64'h0, 1'b0);
    pendIfu = 1'b1; ifuAddr = 64'h8000_0100;
    pendLsu = 1'b1; lsuAddr = 64'h8000_3008;
    runTxn(0, 0, 0, 64'h4444, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 200; i++) begin
      int mode;
      if (!pendIfu && ($urandom % 2 == 1)) begin
        pendIfu = 1'b1; ifuAddr = {$urandom, $urandom};
      end
      if (!pendLsu && ($urandom % 2 == 1)) begin
        pendLsu = 1'b1; lsuAddr = {$urandom, $urandom}; lsuWen = 1'($urandom);
        lsuWdata = {$urandom, $urandom}; lsuOp = 3'($urandom);
      end
      if (!pendIfu && !pendLsu) begin
        pendIfu = 1'b1; ifuAddr = {$urandom, $urandom};
      end
      mode = ($urandom % 8 == 0) ? 1 : 0;
      runTxn(int'($urandom_range(0, 3)), int'($urandom_range(0, TIMEOUT - 1)), mode,
             {$urandom, $urandom}, (mode == 1) && ($urandom % 2 == 1));
    end

    checkBit("queue_drained", expQ.size() == 0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
